div_iter: RTL and testbench

Parametrised multi-cycle integer divider for the MIPS execute stage, serving DIV/DIVU and writing the HI/LO pair. It computes quotient and remainder of WIDTH-bit operands, signed or unsigned, with one restoring step per cycle. A start/busy/done handshake and a cancel input let the pipeline launch, wait on, or abort a division. Divide-by-zero is detected and resolved early with defined results.

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_iter_if.sv | 25 ++
 rtl/div_clz.sv | 18 +
 rtl/div_iter.sv | 182 ++++++++++++++++++
 tb/tb_div_iter.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider: FSM state encoding and
// a conditional two's-complement negate used for |x| and for result sign fix-up.
package div_pkg;

    localparam int DIV_STATE_W = 3;
    // Widest operand the helper supports; callers zero-extend and truncate.
    localparam int DIV_MAX_W   = 64;

    typedef enum logic [DIV_STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } div_state_t;

    // Absolute value when is_neg is the operand's sign bit; also used to
    // re-apply a sign to an unsigned result.
    function automatic logic [DIV_MAX_W-1:0] div_abs(input logic [DIV_MAX_W-1:0] value,
                                                     input logic                 is_neg);
        return is_neg ? -value : value;
    endfunction

endpackage

// File: rtl/div_iter_if.sv
// Launch/result bundle between the execute stage (master) and the divider (slave).
interface div_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             cancel;
    logic             signdiv;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             divzero;

    modport master (
        output start, cancel, signdiv, a, b,
        input  busy, done, q, r, divzero
    );

    modport slave (
        input  start, cancel, signdiv, a, b,
        output busy, done, q, r, divzero
    );
endinterface

// File: rtl/div_clz.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module div_clz #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Ascending scan: the highest set bit is the last one to write count.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) count = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring divider (DIV/DIVU) producing LO=quotient, HI=remainder.
// Define DIV_EARLY_OUT_EN to skip the dividend's leading zeros via div_clz.
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       divrst_n,
    div_iter_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             signdiv_q, signdiv_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             divzero_q, divzero_d;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;

    assign abs_a  = WIDTH'(div_abs(DIV_MAX_W'(a_q), signdiv_q & a_q[WIDTH-1]));
    assign abs_b  = WIDTH'(div_abs(DIV_MAX_W'(b_q), signdiv_q & b_q[WIDTH-1]));

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, divisor_q};

`ifdef DIV_EARLY_OUT_EN
    logic [CNT_W-1:0] clz_k;

    div_clz #(.WIDTH(WIDTH)) u_clz (
        .value (abs_a),
        .count (clz_k)
    );
`endif

    // NOTE: every _d gets its _q as a default first, so no path through the
    // case below leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        signdiv_d = signdiv_q;
        divisor_d = divisor_q;
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        q_d       = q_q;
        r_d       = r_q;
        divzero_d = divzero_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.cancel) begin
                    a_d       = bus.a;
                    b_d       = bus.b;
                    signdiv_d = bus.signdiv;
                    state_d   = S_PREP;
                end
            end

            S_PREP: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    quo_neg_d = signdiv_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    rem_neg_d = signdiv_q & a_q[WIDTH-1];
                    divisor_d = abs_b;
                    rem_d     = '0;
                    if (b_q == '0) begin
                        dz_d    = 1'b1;
                        state_d = S_FIX;
                    end else begin
                        dz_d    = 1'b0;
`ifdef DIV_EARLY_OUT_EN
                        // At least one step always runs so a zero dividend still resolves.
                        dvd_d   = abs_a << clz_k;
                        cnt_d   = (clz_k > CNT_W'(WIDTH - 1)) ? CNT_W'(1)
                                                              : CNT_W'(WIDTH) - clz_k;
`else
                        dvd_d   = abs_a;
                        cnt_d   = CNT_W'(WIDTH);
`endif
                        state_d = S_ITER;
                    end
                end
            end

            S_ITER: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                    dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (dz_q) begin
                        q_d       = '1;
                        r_d       = a_q;
                        divzero_d = 1'b1;
                    end else begin
                        q_d       = WIDTH'(div_abs(DIV_MAX_W'(dvd_q), quo_neg_q));
                        r_d       = WIDTH'(div_abs(DIV_MAX_W'(rem_q), rem_neg_q));
                        divzero_d = 1'b0;
                    end
                    state_d = S_DONE;
                end
            end

            S_DONE:  state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its _d from the same edge regardless of statement order.
    always_ff @(posedge clk or negedge divrst_n) begin
        if (!divrst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            signdiv_q <= 1'b0;
            divisor_q <= '0;
            dvd_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            q_q       <= '0;
            r_q       <= '0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            signdiv_q <= signdiv_d;
            divisor_q <= divisor_d;
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            q_q       <= q_d;
            r_q       <= r_d;
            divzero_q <= divzero_d;
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = (state_q == S_DONE);
    assign bus.q       = q_q;
    assign bus.r       = r_q;
    assign bus.divzero = divzero_q;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: directed vectors push expected results and
// done cycles; a negedge monitor pops and compares whenever done pulses.
module tb_div_iter;

    localparam int WIDTH = 32;

    typedef struct {
        string             name;
        logic [WIDTH-1:0]  q;
        logic [WIDTH-1:0]  r;
        logic              dz;
        int                cyc;
    } exp_t;

    logic clk;
    logic divrst_n;
    int   cyc;
    int   n_checks;
    int   n_pass;
    exp_t sb_q[$];

    logic [WIDTH-1:0] last_q;
    logic [WIDTH-1:0] last_r;
    logic             last_dz;

    div_iter_if #(.WIDTH(WIDTH)) bus ();

    div_iter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .divrst_n (divrst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int lat_sel(input int lat_def, input int lat_eo);
`ifdef DIV_EARLY_OUT_EN
        return lat_eo;
`else
        return lat_def;
`endif
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (divrst_n && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_q"},       64'(bus.q),       64'(e.q));
                check({e.name, "_r"},       64'(bus.r),       64'(e.r));
                check({e.name, "_divzero"}, 64'(bus.divzero), 64'(e.dz));
                check({e.name, "_cycle"},   64'(cyc),         64'(e.cyc));
                check({e.name, "_busy"},    64'(bus.busy),    64'd1);
            end
        end
    end

    // Called just after a rising edge; start is sampled on the next one.
    task automatic issue(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                         input logic sd_i);
        bus.a       = a_i;
        bus.b       = b_i;
        bus.signdiv = sd_i;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic [WIDTH-1:0] q_e,
                                 input logic [WIDTH-1:0] r_e, input logic dz_e, input int lat);
        exp_t e;
        e.name = name;
        e.q    = q_e;
        e.r    = r_e;
        e.dz   = dz_e;
        e.cyc  = cyc + lat;
        sb_q.push_back(e);
        last_q  = q_e;
        last_r  = r_e;
        last_dz = dz_e;
    endtask

    task automatic wait_drain(input string name);
        int i;
        i = 0;
        while (sb_q.size() != 0 && i < 100) begin
            @(posedge clk);
            i++;
        end
        #1;
        check({name, "_drained"}, 64'(sb_q.size()), 64'd0);
        sb_q.delete();
        check({name, "_idle_busy"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic run_vec(input string name, input logic [WIDTH-1:0] a_i,
                           input logic [WIDTH-1:0] b_i, input logic sd_i,
                           input logic [WIDTH-1:0] q_e, input logic [WIDTH-1:0] r_e,
                           input logic dz_e, input int lat_def, input int lat_eo);
        expect_result(name, q_e, r_e, dz_e, lat_sel(lat_def, lat_eo));
        issue(a_i, b_i, sd_i);
        check({name, "_busy_c1"}, 64'(bus.busy), 64'd1);
        wait_drain(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc         = 0;
        n_checks    = 0;
        n_pass      = 0;
        last_q      = '0;
        last_r      = '0;
        last_dz     = 1'b0;
        divrst_n    = 1'b0;
        bus.start   = 1'b0;
        bus.cancel  = 1'b0;
        bus.signdiv = 1'b0;
        bus.a       = '0;
        bus.b       = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",    64'(bus.busy),    64'd0);
        check("rst_done",    64'(bus.done),    64'd0);
        check("rst_q",       64'(bus.q),       64'd0);
        check("rst_r",       64'(bus.r),       64'd0);
        check("rst_divzero", 64'(bus.divzero), 64'd0);
        divrst_n = 1'b1;
        @(posedge clk);
        #1;

        //       name        a             b             sd    q             r             dz    lat  lat_eo
        run_vec("u100_7",    32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0, 35,  10);
        run_vec("s_m7_2",    32'hFFFFFFF9, 32'h2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 35,  6);
        run_vec("s_7_m2",    32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        1'b0, 35,  6);
        run_vec("s_ovf",     32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0, 35,  35);
        run_vec("u_ovf",     32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 1'b0, 35,  35);
        run_vec("s_m100_m7", 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14,       32'hFFFFFFFE, 1'b0, 35,  10);
        run_vec("u_dz",      32'h12345678, 32'd0,        1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1, 3,   3);
        run_vec("s_dz",      32'h80000001, 32'd0,        1'b1, 32'hFFFFFFFF, 32'h80000001, 1'b1, 3,   3);

        // Abandoned operation: cancel sampled at the end of cycle 10.
        issue(32'hFFFF0000, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        bus.cancel = 1'b1;
        @(posedge clk);
        #1;
        bus.cancel = 1'b0;
        check("cancel_busy",    64'(bus.busy),    64'd0);
        check("cancel_hold_q",  64'(bus.q),       64'(last_q));
        check("cancel_hold_r",  64'(bus.r),       64'(last_r));
        check("cancel_hold_dz", 64'(bus.divzero), 64'(last_dz));
        @(posedge clk);
        #1;

        // Follow-up 9/3 with a stray start mid-flight that must be ignored.
        expect_result("u9_3", 32'd3, 32'd0, 1'b0, lat_sel(35, 7));
        issue(32'd9, 32'd3, 1'b0);
        check("u9_3_busy_c1", 64'(bus.busy), 64'd1);
        @(posedge clk);
        #1;
        bus.a       = 32'd1000;
        bus.b       = 32'd1;
        bus.signdiv = 1'b1;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        wait_drain("u9_3");

        run_vec("u5_3",      32'd5,        32'd3,        1'b0, 32'd1,        32'd2,        1'b0, 35,  6);
        run_vec("u0_5",      32'd0,        32'd5,        1'b0, 32'd0,        32'd0,        1'b0, 35,  4);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
